// File: rtl/rf_wb_arbiter_pkg.sv
// ============================================================================
// Module : rf_wb_arbiter_pkg
// Brief  : Shared constants and arbiter state encoding for the RF write arbiter
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rf_wb_arbiter_pkg;

    localparam int          c_reg_aw    = 5;
    localparam logic [31:0] c_zero_word = 32'h0000_0000;

    typedef enum logic [0:0] {
        PIPE_PRI = 1'b0,
        LU_FORCE = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_reg_scoreboard.sv
// ============================================================================
// Module : reg_scoreboard
// Brief  : Busy bits for registers awaiting long-unit results; issue hazard check
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = c_reg_aw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rs1,
    input  logic [AW-1:0] iss_rs2,
    input  logic          iss_use_rs1,
    input  logic          iss_use_rs2,
    input  logic          iss_we,
    input  logic [AW-1:0] iss_rd,
    input  logic          iss_long,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    output logic          iss_stall
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_set;

    assign iss_stall = iss_valid & ((iss_use_rs1 & r_busy[iss_rs1]) |
                                    (iss_use_rs2 & r_busy[iss_rs2]) |
                                    (iss_we      & r_busy[iss_rd]));

    assign w_set = iss_valid & ~iss_stall & iss_we & iss_long & (iss_rd != '0);

    // x0 never becomes busy; set and clear of one index cannot coincide (WAW stall)
    assign w_busy_nxt[0] = 1'b0;
    for (genvar i = 1; i < NREG; i++) begin : g_busy
        assign w_busy_nxt[i] = (w_set & (iss_rd == AW'(i))) |
                               (r_busy[i] & ~(clr_en & (clr_idx == AW'(i))));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module : rf_wb_arbiter
// Brief  : Shares the RF write port between WB stage and long-latency unit
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int AW         = c_reg_aw,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic            iss_use_rs1,
    input  logic            iss_use_rs2,
    input  logic            iss_we,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_long,
    output logic            iss_stall,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            lu_valid,
    input  logic [AW-1:0]   lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int CW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [CW-1:0] r_starve;
    logic [CW-1:0] w_starve_nxt;
    logic          r_wr_is_lu;
    logic          w_wb_grant;
    logic          w_lu_grant;

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_use_rs1 (iss_use_rs1),
        .iss_use_rs2 (iss_use_rs2),
        .iss_we      (iss_we),
        .iss_rd      (iss_rd),
        .iss_long    (iss_long),
        .clr_en      (rf_we & r_wr_is_lu),
        .clr_idx     (rf_rd),
        .iss_stall   (iss_stall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= PIPE_PRI;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Pipeline wins by default; after STARVE_MAX lost cycles the long unit gets one forced slot
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = '0;
        wb_ready     = 1'b1;
        lu_ready     = ~wb_valid;
        case (r_state)
            PIPE_PRI: begin
                if (lu_valid & wb_valid) begin
                    if (r_starve == CW'(STARVE_MAX - 1)) begin
                        w_state_nxt = LU_FORCE;
                    end else begin
                        w_starve_nxt = r_starve + 1'b1;
                    end
                end
            end
            LU_FORCE: begin
                wb_ready    = 1'b0;
                lu_ready    = 1'b1;
                w_state_nxt = PIPE_PRI;
            end
            default: begin
                w_state_nxt = PIPE_PRI;
            end
        endcase
    end

    assign w_wb_grant = wb_valid & wb_ready;
    assign w_lu_grant = lu_valid & lu_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wdata   <= XLEN'(c_zero_word);
            r_wr_is_lu <= 1'b0;
        end else if (w_lu_grant) begin
            rf_we      <= (lu_rd != '0);
            rf_rd      <= lu_rd;
            rf_wdata   <= lu_data;
            r_wr_is_lu <= 1'b1;
        end else if (w_wb_grant) begin
            rf_we      <= (wb_rd != '0);
            rf_rd      <= wb_rd;
            rf_wdata   <= wb_data;
            r_wr_is_lu <= 1'b0;
        end else begin
            rf_we      <= 1'b0;
            r_wr_is_lu <= 1'b0;
        end
    end

endmodule

`default_nettype wire
